// File: rtl/encoder_pkg.sv
// Shared constants and types for the slice-wise matrix-encoder sequencer.
// Geometry, step encodings and the controller state enum live here.
package encoder_pkg;

    localparam int SLICES    = 64;
    localparam int ADDR_W    = 6;
    localparam int LINE_W    = 25;
    localparam int ROUNDS    = 24;
    localparam int NUM_STEPS = 3;
    localparam int ROUND_W   = 5;

    localparam logic [1:0] STEP_COLPARITY = 2'd0;
    localparam logic [1:0] STEP_PERMUTE   = 2'd1;
    localparam logic [1:0] STEP_NONLIN    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_UNLOAD = 3'd4
    } seq_state_e;

endpackage

// File: rtl/seq_skid_fifo.sv
// Two-entry valid/ready buffer for the unload stream. Occupancy is exported so
// the controller can grant RAM read credit without ever overflowing it.
module seq_skid_fifo
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [LINE_W-1:0] push_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [LINE_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [LINE_W-1:0] head_r, head_s;
    logic [LINE_W-1:0] tail_r, tail_s;
    logic [1:0]        cnt_r, cnt_s;
    logic              pop_s;

    assign pop_s     = out_ready && (cnt_r != 2'd0);
    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = head_r;
    assign occupancy = cnt_r;

    // Next-state of the buffer; head always holds the oldest entry
    always_comb begin
        head_s = head_r;
        tail_s = tail_r;
        cnt_s  = cnt_r;
        case ({push, pop_s})
            2'b10: begin
                if (cnt_r == 2'd0) begin
                    head_s = push_data;
                    cnt_s  = 2'd1;
                end else if (cnt_r == 2'd1) begin
                    tail_s = push_data;
                    cnt_s  = 2'd2;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            2'b01: begin
                head_s = tail_r;
                cnt_s  = cnt_r - 2'd1;
            end
            2'b11: begin
                if (cnt_r == 2'd1) begin
                    head_s = push_data;
                end else begin
                    head_s = tail_r;
                    tail_s = push_data;
                end
            end
            default: begin
                cnt_s = cnt_r;
            end
        endcase
    end

    // Buffer storage and occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {LINE_W{1'b0}};
            tail_r <= {LINE_W{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            head_r <= head_s;
            tail_r <= tail_s;
            cnt_r  <= cnt_s;
        end
    end

endmodule

// File: rtl/encoder_sequencer.sv
// Sequencer for the slice-wise encoder: loads a state into bank 0, runs
// ROUNDS x NUM_STEPS ping-pong passes through the datapath, then streams it out.
module encoder_sequencer #(
    parameter int SLICES    = encoder_pkg::SLICES,
    parameter int ADDR_W    = encoder_pkg::ADDR_W,
    parameter int ROUNDS    = encoder_pkg::ROUNDS,
    parameter int NUM_STEPS = encoder_pkg::NUM_STEPS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [encoder_pkg::LINE_W-1:0]   in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [encoder_pkg::LINE_W-1:0]   out_data,
    output logic                             mem_rd_en,
    output logic [ADDR_W:0]                  mem_rd_addr_a,
    output logic [ADDR_W:0]                  mem_rd_addr_b,
    input  logic [encoder_pkg::LINE_W-1:0]   mem_rd_data_a,
    output logic                             mem_wr_en,
    output logic [ADDR_W:0]                  mem_wr_addr,
    output logic [encoder_pkg::LINE_W-1:0]   mem_wr_data,
    output logic [1:0]                       dp_step,
    output logic [encoder_pkg::ROUND_W-1:0]  dp_round,
    input  logic [encoder_pkg::LINE_W-1:0]   dp_result
);

    import encoder_pkg::*;

    seq_state_e         state_r, state_s;
    logic [ADDR_W-1:0]  cnt_r, cnt_s;
    logic [ADDR_W-1:0]  ocnt_r, ocnt_s;
    logic [ADDR_W-1:0]  prev_s;
    logic [1:0]         step_r, step_s;
    logic [ROUND_W-1:0] round_r, round_s;
    logic               rb_r, rb_s;
    logic               wr_pend_r, wr_pend_s;
    logic [ADDR_W:0]    wr_addr_r, wr_addr_s;
    logic               inflight_r, inflight_s;
    logic               rd_all_r, rd_all_s;
    logic               done_r, done_s;

    logic               load_hs_s, out_hs_s, last_slice_s, last_pass_s, unl_rd_s;
    logic [1:0]         fifo_occ_s;
    logic [2:0]         credit_s;

    assign load_hs_s    = (state_r == ST_LOAD) && in_valid;
    assign out_hs_s     = out_valid && out_ready;
    assign last_slice_s = (cnt_r == ADDR_W'(SLICES - 1));
    assign last_pass_s  = (round_r == ROUND_W'(ROUNDS - 1)) && (step_r == 2'(NUM_STEPS - 1));
    assign prev_s       = (cnt_r == {ADDR_W{1'b0}}) ? ADDR_W'(SLICES - 1) : cnt_r - ADDR_W'(1);

    // Credit counts the slot freed by a pop this cycle so back-to-back reads sustain 1 slice/cycle
    assign credit_s = {1'b0, fifo_occ_s} + {2'b00, inflight_r} - {2'b00, out_hs_s};
    assign unl_rd_s = (state_r == ST_UNLOAD) && !rd_all_r && (credit_s < 3'd2);

    // Next-state and counter updates for the controller
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        ocnt_s     = ocnt_r;
        step_s     = step_r;
        round_s    = round_r;
        rb_s       = rb_r;
        wr_pend_s  = 1'b0;
        wr_addr_s  = wr_addr_r;
        inflight_s = unl_rd_s;
        rd_all_s   = rd_all_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_LOAD;
                    cnt_s    = {ADDR_W{1'b0}};
                    ocnt_s   = {ADDR_W{1'b0}};
                    rb_s     = 1'b0;
                    step_s   = 2'd0;
                    round_s  = {ROUND_W{1'b0}};
                    rd_all_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_hs_s) begin
                    cnt_s = cnt_r + ADDR_W'(1);
                    if (last_slice_s) begin
                        state_s = ST_RUN;
                        cnt_s   = {ADDR_W{1'b0}};
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_RUN: begin
                wr_pend_s = 1'b1;
                wr_addr_s = {~rb_r, cnt_r};
                cnt_s     = cnt_r + ADDR_W'(1);
                if (last_slice_s) begin
                    state_s = ST_FLUSH;
                    cnt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                rb_s = ~rb_r;
                if (last_pass_s) begin
                    state_s  = ST_UNLOAD;
                    step_s   = 2'd0;
                    round_s  = {ROUND_W{1'b0}};
                    cnt_s    = {ADDR_W{1'b0}};
                    ocnt_s   = {ADDR_W{1'b0}};
                    rd_all_s = 1'b0;
                end else if (step_r == 2'(NUM_STEPS - 1)) begin
                    state_s = ST_RUN;
                    step_s  = 2'd0;
                    round_s = round_r + ROUND_W'(1);
                end else begin
                    state_s = ST_RUN;
                    step_s  = step_r + 2'd1;
                end
            end
            ST_UNLOAD: begin
                if (unl_rd_s) begin
                    cnt_s    = cnt_r + ADDR_W'(1);
                    rd_all_s = last_slice_s;
                end else begin
                    cnt_s = cnt_r;
                end
                if (out_hs_s) begin
                    ocnt_s = ocnt_r + ADDR_W'(1);
                    if (ocnt_r == ADDR_W'(SLICES - 1)) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_UNLOAD;
                    end
                end else begin
                    ocnt_s = ocnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {ADDR_W{1'b0}};
            ocnt_r     <= {ADDR_W{1'b0}};
            step_r     <= 2'd0;
            round_r    <= {ROUND_W{1'b0}};
            rb_r       <= 1'b0;
            wr_pend_r  <= 1'b0;
            wr_addr_r  <= {(ADDR_W + 1){1'b0}};
            inflight_r <= 1'b0;
            rd_all_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ocnt_r     <= ocnt_s;
            step_r     <= step_s;
            round_r    <= round_s;
            rb_r       <= rb_s;
            wr_pend_r  <= wr_pend_s;
            wr_addr_r  <= wr_addr_s;
            inflight_r <= inflight_s;
            rd_all_r   <= rd_all_s;
            done_r     <= done_s;
        end
    end

    seq_skid_fifo u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (mem_rd_data_a),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (fifo_occ_s)
    );

    assign busy          = (state_r != ST_IDLE);
    assign in_ready      = (state_r == ST_LOAD);
    assign done          = done_r;
    assign mem_rd_en     = (state_r == ST_RUN) || unl_rd_s;
    assign mem_rd_addr_a = mem_rd_en ? {rb_r, cnt_r} : {(ADDR_W + 1){1'b0}};
    assign mem_rd_addr_b = (state_r == ST_RUN) ? {rb_r, prev_s} : {(ADDR_W + 1){1'b0}};
    assign mem_wr_en     = load_hs_s || wr_pend_r;
    assign mem_wr_addr   = load_hs_s ? {1'b0, cnt_r} : (wr_pend_r ? wr_addr_r : {(ADDR_W + 1){1'b0}});
    assign mem_wr_data   = load_hs_s ? in_data : (wr_pend_r ? dp_result : {LINE_W{1'b0}});
    assign dp_step       = step_r;
    assign dp_round      = round_r;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Randomized scoreboard bench for encoder_sequencer: a two-bank RAM and a
// selectable datapath surround the DUT; expectations come from an array model.
module tb_encoder_sequencer;

    localparam int SLICES    = 64;
    localparam int TB_ROUNDS = 4;
    localparam int RUN_READS = TB_ROUNDS * 3 * SLICES;

    logic        clk, rst_n, start, busy, done;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [24:0] in_data, out_data;
    logic        mem_rd_en, mem_wr_en;
    logic [6:0]  mem_rd_addr_a, mem_rd_addr_b, mem_wr_addr;
    logic [24:0] mem_rd_data_a, mem_wr_data, dp_result;
    logic [1:0]  dp_step;
    logic [4:0]  dp_round;

    logic [24:0] ram [128];
    logic [24:0] rda, rdb;
    logic [24:0] exp_q [$];

    int checks = 0, errors = 0;
    int cyc = 0, dp_mode = 0, ready_pct = 100;
    int done_cnt = 0, first_ov = 0, max_out = 0;
    int rd_total = 0, hs_total = 0;

    encoder_sequencer #(.ROUNDS(TB_ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
        .mem_rd_data_a(mem_rd_data_a), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .dp_step(dp_step), .dp_round(dp_round), .dp_result(dp_result)
    );

    function automatic logic [24:0] dpf(input int mode, input logic [24:0] a, input logic [24:0] b,
                                        input logic [1:0] st, input logic [4:0] rd);
        if (mode == 0) return a;
        else if (mode == 1) return a ^ b;
        else return (a ^ {b[23:0], b[24]}) + {18'd0, st, rd};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Two-bank slice RAM with one-cycle read latency on both ports
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            rda <= ram[mem_rd_addr_a];
            rdb <= ram[mem_rd_addr_b];
        end
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    end

    assign mem_rd_data_a = rda;
    assign dp_result     = dpf(dp_mode, rda, rdb, dp_step, dp_round);

    initial forever begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops on every output handshake and tracks outstanding unload reads
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (out_valid && first_ov == 0) first_ov = cyc;
            if (busy && mem_rd_en) rd_total++;
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=%0h expected=none", out_data);
                end else begin
                    check("out_data", {7'd0, out_data}, {7'd0, exp_q.pop_front()});
                end
            end
            if (rd_total > RUN_READS && (rd_total - RUN_READS - hs_total) > max_out)
                max_out = rd_total - RUN_READS - hs_total;
            if (done) done_cnt++;
            if (!busy) begin
                rd_total = 0;
                hs_total = 0;
            end
        end
    end

    task automatic run_encode(input int mode, input bit idx_data, input int gap_pct, input int rdy,
                              input bit first, input bit abort);
        logic [24:0] d   [SLICES];
        logic [24:0] cur [SLICES];
        logic [24:0] nxt [SLICES];
        int i, g, last_ld, target;
        dp_mode   = mode;
        ready_pct = rdy;
        done_cnt  = 0;
        first_ov  = 0;
        max_out   = 0;
        for (int s = 0; s < SLICES; s++) d[s] = idx_data ? 25'(s) : 25'($urandom);
        if (!abort) begin
            cur = d;
            for (int r = 0; r < TB_ROUNDS; r++)
                for (int st = 0; st < 3; st++) begin
                    for (int s = 0; s < SLICES; s++)
                        nxt[s] = dpf(mode, cur[s], cur[(s + SLICES - 1) % SLICES], 2'(st), 5'(r));
                    cur = nxt;
                end
            for (int s = 0; s < SLICES; s++) exp_q.push_back(cur[s]);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        i = 0; g = 0; last_ld = 0;
        while (i < SLICES && g < 4000) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = d[i];
            @(negedge clk);
            g++;
            if (in_valid && in_ready) begin
                i++;
                last_ld = cyc;
            end
        end
        check("load_count", i, SLICES);
        @(posedge clk); #1 in_valid = 1'b0;
        if (first) begin
            @(negedge clk);
            check("wrap_rd_en", mem_rd_en, 1);
            check("wrap_addr_a", mem_rd_addr_a, 7'd0);
            check("wrap_addr_b", mem_rd_addr_b, 7'd63);
            @(negedge clk);
            check("wrap_wr_en", mem_wr_en, 1);
            check("wrap_wr_addr", mem_wr_addr, 7'd64);
            repeat (64) @(negedge clk);
            check("pass1_addr_a", mem_rd_addr_a, 7'd64);
            check("pass1_addr_b", mem_rd_addr_b, 7'd127);
        end else if (!abort) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            repeat (5) @(posedge clk);
            #1 start = 1'b0;
        end
        if (abort) begin
            target = last_ld + 1 + 10 * 65 + 17;
            while (cyc < target) @(negedge clk);
            check("abort_point_addr", mem_rd_addr_a, 7'd17);
            check("abort_point_step", dp_step, 2'd1);
            check("abort_point_round", dp_round, 5'd3);
            #1 rst_n = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_rd_en", mem_rd_en, 0);
            check("abort_wr_en", mem_wr_en, 0);
            @(posedge clk); #1 rst_n = 1'b1;
            repeat (6) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            check("abort_idle", busy, 0);
        end else begin
            g = 0;
            while (done !== 1'b1 && g < 20000) begin
                @(negedge clk);
                g++;
            end
            check("done_seen", done, 1);
            check("busy_low_at_done", busy, 0);
            repeat (4) @(negedge clk);
            check("done_once", done_cnt, 1);
            check("scoreboard_drained", exp_q.size(), 0);
            check("outstanding_le2", (max_out <= 2), 1);
            if (first) check("load_to_out_latency", first_ov - last_ld - 1, TB_ROUNDS * 3 * 65 + 2);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b0; in_data = 25'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1 start = 1'b0; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_without_start", busy, 0);

        run_encode(0, 1'b1, 0, 100, 1'b1, 1'b0);
        run_encode(1, 1'b0, 0, 100, 1'b0, 1'b0);
        run_encode(2, 1'b0, 40, 30, 1'b0, 1'b0);
        run_encode(2, 1'b0, 0, 100, 1'b0, 1'b1);
        run_encode(2, 1'b0, 20, 60, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/encoder_sequencer.md
Name: encoder_sequencer

Overview:
Controller that sequences the slice-wise matrix-encoder datapath (column-parity / permutation / nonlinear steps) over a 5x5xSLICES state held in an external two-bank slice memory. It streams a state in, runs ROUNDS x NUM_STEPS passes, and streams the result out. Each pass reads the current slice and its predecessor slice from one bank and writes the datapath result into the other bank (ping-pong). It sits between the host stream interface, the slice RAM and the combinational step datapath.

Parameters:
SLICES, 64, slices per state; each slice is one 25-bit line
ADDR_W, 6, log2(SLICES)
ROUNDS, 24, rounds per encode
NUM_STEPS, 3, datapath steps per round (0 = column parity, 1 = permute, 2 = nonlinear)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin encode; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on final unload handshake
in_valid  in  1  load stream valid
in_ready  out  1  load stream ready
in_data  in  25  load slice, slice 0 first
out_valid  out  1  unload stream valid
out_ready  in  1  unload stream ready
out_data  out  25  unload slice, slice 0 first
mem_rd_en  out  1  read strobe, both ports
mem_rd_addr_a  out  ADDR_W+1  {bank, slice s}
mem_rd_addr_b  out  ADDR_W+1  {bank, (s-1) mod SLICES}
mem_rd_data_a  in  25  data for addr_a, 1 cycle after mem_rd_en
mem_wr_en  out  1  write strobe
mem_wr_addr  out  ADDR_W+1  {bank, slice}
mem_wr_data  out  25  load data or dp_result
dp_step  out  2  step select to datapath
dp_round  out  5  round index to datapath
dp_result  in  25  combinational datapath output for current read pair

Behaviour:
- Reset: state IDLE; all outputs 0; counters and bank pointer 0. Memory contents not cleared. Asserting rst_n low mid-operation aborts immediately; no done.
- States: IDLE, LOAD, RUN, FLUSH, UNLOAD.
- IDLE: start=1 -> LOAD, slice counter 0, bank 0. start in any other state ignored.
- LOAD: in_ready=1. Each in_valid&in_ready writes in_data to {0, cnt} same cycle (mem_wr_en combinational from handshake); cnt++. After slice SLICES-1 accepted -> RUN, step 0, round 0. Gaps in in_valid stall without side effects.
- RUN: one slice per cycle. Cycle t: mem_rd_en=1, addr_a={rb, s}, addr_b={rb, (s-1) mod SLICES} (s=0 -> SLICES-1). Cycle t+1: mem_wr_en=1, mem_wr_addr={~rb, s} registered, mem_wr_data=dp_result. dp_step/dp_round held constant for the whole pass, including the trailing write. After issuing s=SLICES-1 -> FLUSH.
- FLUSH: one bubble cycle, performs the last write, no read. Avoids the read-after-write hazard on slice SLICES-1 at the next pass's slice 0. Then rb toggles and step++. step wraps NUM_STEPS-1 -> 0 with round++. After round ROUNDS-1, step NUM_STEPS-1 -> UNLOAD, else -> RUN.
- Pass cost SLICES+1 cycles; run phase ROUNDS*NUM_STEPS*(SLICES+1) cycles (4680 at defaults).
- UNLOAD: reads bank rb (parity of ROUNDS*NUM_STEPS) sequentially. Output uses a 2-entry skid FIFO. A read issues only when (entries + in-flight) < 2; read data enters the FIFO next cycle. out_data/out_valid come from the FIFO head. This sustains 1 slice/cycle with out_ready held high. Backpressure never drops or duplicates slices.
- Final out handshake (slice SLICES-1): done=1 for that cycle's successor edge; state -> IDLE.
- busy=0 and done=1 never overlap beyond the IDLE-entry cycle. done is registered and asserted in the first IDLE cycle.

Decomposition:
- Package encoder_pkg: SLICES, ADDR_W, LINE_W=25, state enum, step encodings (STEP_COLPARITY=0, STEP_PERMUTE=1, STEP_NONLIN=2), ROUNDS.
- Sub-module seq_skid_fifo: 2-entry, 25-bit valid/ready buffer with occupancy output used for read credit.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> busy, in_ready, out_valid, mem_wr_en, done all 0; release -> stays IDLE until a start pulse.
- Identity pass (ROUNDS=1, bench datapath returns mem_rd_data_a): load slices 0..63 = index -> out_data sequence 0..63. done pulses once. Total cycles from last load to first out_valid = 3*65 + 2.
- Wrap: first RUN cycle -> addr_a={0,0}, addr_b={0,63}. The following write goes to {1,0}, and the next pass reads bank 1.
- Hazard: datapath = a XOR b, ROUNDS=1. Compare against a software model -> exact match, which proves the FLUSH bubble and correct bank toggling.
- Backpressure: out_ready random 30% duty -> 64 slices in order, none lost or duplicated, at most 2 outstanding. Load with in_valid gaps -> same result as gapless.
- Abort: start during RUN ignored. rst_n low at pass 10 slice 17 -> immediate IDLE, no done. A new start completes normally.
